// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronizer, 3-sample majority vote per bit,
// optional parity, 1 or 2 stop bits, and a one-deep holding register with overrun flag.
module uart_rx_cfg #(
    parameter int BAUD_DIV  = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] CNT_DEC  = CW'(BAUD_DIV / 2 + 1);
    localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PAR     = 3'd3,
        STOP    = 3'd4,
        HOLDOFF = 3'd5
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_fail(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        if (PARITY == 1) begin
            return ~x;
        end else if (PARITY == 2) begin
            return x;
        end else begin
            return 1'b0;
        end
    endfunction

    logic                 rx_meta_r;
    logic                 rx_s;
    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [3:0]           bit_cnt_r;
    logic                 stop_cnt_r;
    logic [1:0]           samp_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 ferr_r;
    logic                 perr_r;

    logic vote_s;
    logic at_dec_s;
    logic at_end_s;
    logic complete_s;
    logic ferr_fin_s;

    assign vote_s     = majority3(samp_r[1], samp_r[0], rx_s);
    assign at_dec_s   = (cnt_r == CNT_DEC);
    assign at_end_s   = (cnt_r == CNT_LAST);
    assign complete_s = (state_r == STOP) && at_dec_s && (stop_cnt_r == STOP_LAST);
    assign ferr_fin_s = ferr_r | ~vote_s;

    // Two-flop synchronizer on the asynchronous serial line, idling high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
        end
    end

    // Receive FSM with bit-time counter, vote samples and per-character error accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            bit_cnt_r  <= 4'd0;
            stop_cnt_r <= 1'b0;
            samp_r     <= 2'b11;
            shift_r    <= '0;
            ferr_r     <= 1'b0;
            perr_r     <= 1'b0;
        end else begin
            if (cnt_r == CNT_S0) samp_r[0] <= rx_s;
            if (cnt_r == CNT_S1) samp_r[1] <= rx_s;
            cnt_r <= at_end_s ? '0 : cnt_r + CW'(1);
            case (state_r)
                IDLE: begin
                    cnt_r      <= '0;
                    bit_cnt_r  <= 4'd0;
                    stop_cnt_r <= 1'b0;
                    ferr_r     <= 1'b0;
                    perr_r     <= 1'b0;
                    if (!rx_s) state_r <= START;
                end
                START: begin
                    if (at_dec_s && vote_s) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end else if (at_end_s) begin
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (at_dec_s) shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
                    if (at_end_s) begin
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                PAR: begin
                    if (at_dec_s) perr_r <= parity_fail(shift_r, vote_s);
                    if (at_end_s) state_r <= STOP;
                end
                STOP: begin
                    // The last stop bit finishes the character at its decision point
                    if (complete_s) begin
                        state_r <= vote_s ? IDLE : HOLDOFF;
                        cnt_r   <= '0;
                    end else begin
                        if (at_dec_s) ferr_r <= ferr_fin_s;
                        if (at_end_s) stop_cnt_r <= 1'b1;
                    end
                end
                HOLDOFF: begin
                    cnt_r <= '0;
                    if (rx_s) state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Holding register, valid/ready handshake and sticky overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (complete_s && (!valid || ready)) begin
                data       <= shift_r;
                frame_err  <= ferr_fin_s;
                parity_err <= perr_r;
                valid      <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (complete_s && valid && !ready) begin
                overrun <= 1'b1;
            end else if (valid && ready) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance, both at 8 clk per bit.
module tb_uart_rx_cfg;

    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx0, rx1, ready0, ready1;
    logic [7:0] data0;
    logic [6:0] data1;
    logic       valid0, ferr0, perr0, ovr0;
    logic       valid1, ferr1, perr1, ovr1;

    typedef struct packed {
        logic [8:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .data(data0), .valid(valid0), .ready(ready0),
        .frame_err(ferr0), .parity_err(perr0), .overrun(ovr0)
    );

    uart_rx_cfg #(.BAUD_DIV(B), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .data(data1), .valid(valid1), .ready(ready1),
        .frame_err(ferr1), .parity_err(perr1), .overrun(ovr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected character from the line-level frame contents
    function automatic exp_t model(input int inst, input logic [8:0] d, input logic pbit,
                                   input logic [1:0] stops);
        exp_t e;
        int   db, par, sb, ones;
        db = (inst == 0) ? 8 : 7;
        par = (inst == 0) ? 0 : 2;
        sb = (inst == 0) ? 1 : 2;
        e.data = d & 9'((1 << db) - 1);
        ones = $countones(e.data) + int'(pbit);
        if (par == 0) e.perr = 1'b0;
        else if (par == 1) e.perr = (ones % 2 == 0);
        else e.perr = (ones % 2 == 1);
        e.ferr = (stops[0] == 1'b0) || (sb == 2 && stops[1] == 1'b0);
        return e;
    endfunction

    task automatic drive_bit(input int inst, input logic v);
        if (inst == 0) rx0 = v;
        else rx1 = v;
        repeat (B) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int inst, input int n);
        if (inst == 0) rx0 = 1'b1;
        else rx1 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int inst, input logic [8:0] d, input logic pbit,
                              input logic [1:0] stops, input bit push);
        int db, sb;
        db = (inst == 0) ? 8 : 7;
        sb = (inst == 0) ? 1 : 2;
        if (push) begin
            if (inst == 0) q0.push_back(model(inst, d, pbit, stops));
            else q1.push_back(model(inst, d, pbit, stops));
        end
        drive_bit(inst, 1'b0);
        for (int i = 0; i < db; i++) drive_bit(inst, d[i]);
        if (inst == 1) drive_bit(inst, pbit);
        for (int i = 0; i < sb; i++) drive_bit(inst, stops[i]);
        idle(inst, 0);
    endtask

    // Monitor: every handshake consumes one expected character
    always @(negedge clk) begin
        exp_t e;
        if (valid0 === 1'b1 && ready0 === 1'b1) begin
            if (q0.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut0_unexpected: got data %0h, expected no character", data0);
            end else begin
                e = q0.pop_front();
                check("dut0_data", 32'(data0), 32'(e.data));
                check("dut0_frame_err", 32'(ferr0), 32'(e.ferr));
                check("dut0_parity_err", 32'(perr0), 32'(e.perr));
            end
        end
        if (valid1 === 1'b1 && ready1 === 1'b1) begin
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut1_unexpected: got data %0h, expected no character", data1);
            end else begin
                e = q1.pop_front();
                check("dut1_data", 32'(data1), 32'(e.data));
                check("dut1_frame_err", 32'(ferr1), 32'(e.ferr));
                check("dut1_parity_err", 32'(perr1), 32'(e.perr));
            end
        end
    end

    initial begin
        int          n;
        logic [8:0]  d;
        logic        pb;
        logic [1:0]  st;
        logic [7:0]  part;

        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        ready0 = 1'b1;
        ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(valid0), 32'd0);
        check("reset_data", 32'(data0), 32'd0);
        check("reset_flags", 32'({ferr0, perr0, ovr0, valid1, ferr1, perr1, ovr1}), 32'd0);
        rst = 1'b0;
        idle(0, 5);

        // 0xA5, 8N1: sync(2) + idle detect(1) + 9 full bits + decision at count 5 + 1 load
        n = 0;
        fork
            send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1);
            begin
                while (valid0 !== 1'b1 && n < 200) begin
                    @(posedge clk);
                    n++;
                    #1;
                end
            end
        join
        check("a5_latency", 32'(n), 32'(3 + B * 9 + (B / 2 + 1) + 1));
        @(posedge clk);
        #1;
        check("a5_single_pulse", 32'(valid0), 32'd0);
        idle(0, 5);

        // Short glitch must not produce a character; a clean frame follows
        rx0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(0, 60);
        check("glitch_no_valid", 32'(valid0), 32'd0);
        send_frame(0, 9'h05C, 1'b0, 2'b11, 1'b1);
        idle(0, 5);

        // Break: three character times low gives exactly one framed-error zero character
        q0.push_back(model(0, 9'h000, 1'b0, 2'b00));
        rx0 = 1'b0;
        repeat (30 * B) @(posedge clk);
        #1;
        check("break_no_extra", 32'(q0.size()), 32'd0);
        idle(0, 20);

        // Overrun: second character lost while the first is held
        ready0 = 1'b0;
        send_frame(0, 9'h011, 1'b0, 2'b11, 1'b1);
        idle(0, 3);
        send_frame(0, 9'h022, 1'b0, 2'b11, 1'b0);
        idle(0, 5);
        check("ovr_valid_held", 32'(valid0), 32'd1);
        check("ovr_data_held", 32'(data0), 32'h11);
        check("ovr_flag", 32'(ovr0), 32'd1);
        ready0 = 1'b1;
        @(posedge clk);
        #1;
        ready0 = 1'b0;
        check("ovr_hs_valid", 32'(valid0), 32'd0);
        check("ovr_hs_clear", 32'(ovr0), 32'd0);

        // Reset in the middle of data bit 3 with a held character and overrun pending
        send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b0);
        idle(0, 3);
        send_frame(0, 9'h066, 1'b0, 2'b11, 1'b0);
        idle(0, 5);
        check("pre_rst_ovr", 32'(ovr0), 32'd1);
        part = 8'h3C;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, part[i]);
        rx0 = part[3];
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", 32'({data0, valid0, ferr0, perr0, ovr0}), 32'd0);
        rx0 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready0 = 1'b1;
        idle(0, 10);
        send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b1);
        idle(0, 5);

        // 7E2: wrong then right parity bit for 0x07, then a bad second stop bit
        send_frame(1, 9'h007, 1'b0, 2'b11, 1'b1);
        idle(1, 4);
        send_frame(1, 9'h007, 1'b1, 2'b11, 1'b1);
        idle(1, 4);
        send_frame(1, 9'h055, 1'b0, 2'b01, 1'b1);
        idle(1, 6);

        // Randomized frames on both formats with occasional parity and stop errors
        for (int i = 0; i < 40; i++) begin
            int inst;
            inst = i % 2;
            d = 9'($urandom);
            st = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
            pb = (^d[6:0]) ^ ($urandom_range(0, 3) == 0);
            send_frame(inst, d, pb, st, 1'b1);
            idle(inst, $urandom_range(1, 12));
        end

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        while (q0.size() != 0) begin
            void'(q0.pop_front());
            vectors++;
            miscompares++;
            $display("FAIL dut0_missing: got no character, expected one more");
        end
        while (q1.size() != 0) begin
            void'(q1.pop_front());
            vectors++;
            miscompares++;
            $display("FAIL dut1_missing: got no character, expected one more");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
